// File: rtl/limit_pkg.sv
// Shared helpers for the limit scheduler: offset-binary/two's-complement conversion,
// the midscale constant and the channel-index width function.
package limit_pkg;

  localparam int MAX_W = 32;
  localparam logic [7:0] MIDSCALE = 8'h80;

  // Offset-binary and two's complement differ only in the MSB.
  function automatic logic [MAX_W-1:0] to_signed(input logic [MAX_W-1:0] x, input int w);
    return x ^ (MAX_W'(1) << (w - 1));
  endfunction

  function automatic logic [MAX_W-1:0] to_offset(input logic [MAX_W-1:0] x, input int w);
    return x ^ (MAX_W'(1) << (w - 1));
  endfunction

  function automatic int chan_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/limit_clamp.sv
// Combinational clamp of one offset-binary sample against runtime lower/upper bounds.
module limit_clamp
  import limit_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] lower,
  input  logic [N-1:0] upper,
  output logic [N-1:0] y,
  output logic         clipped
);

  logic signed [N-1:0] xS;
  logic signed [N-1:0] lowerS;
  logic signed [N-1:0] upperS;

  assign xS     = N'(to_signed(MAX_W'(x), N));
  assign lowerS = N'(to_signed(MAX_W'(lower), N));
  assign upperS = N'(to_signed(MAX_W'(upper), N));

  always_comb begin
    y       = x;
    clipped = 1'b0;
    if (xS < lowerS) begin
      y       = lower;
      clipped = 1'b1;
    end else if (xS > upperS) begin
      y       = upper;
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/limit_scheduler.sv
// Round-robin arbiter feeding a shared clamp with per-channel bounds and a tagged output register.
// Optional status outputs (Out_Clipped, Sat_Flags) are built when LIMIT_SCHEDULER_STATUS_EN is defined.
module limit_scheduler
  import limit_pkg::*;
#(
  parameter int           N         = 8,
  parameter int           CHANNELS  = 4,
  parameter logic [N-1:0] DEF_LOWER = 8'h00,
  parameter logic [N-1:0] DEF_UPPER = 8'hFF,
  localparam int          CHAN_W    = chan_width(CHANNELS)
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic [CHANNELS-1:0]   In_Valid,
  output logic [CHANNELS-1:0]   In_Ready,
  input  logic [CHANNELS*N-1:0] In_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [N-1:0]          Out_Data,
  output logic [CHAN_W-1:0]     Out_Chan,
`ifdef LIMIT_SCHEDULER_STATUS_EN
  output logic                  Out_Clipped,
  output logic [CHANNELS-1:0]   Sat_Flags,
`endif
  input  logic                  Cfg_Write,
  input  logic [CHAN_W-1:0]     Cfg_Chan,
  input  logic [N-1:0]          Cfg_Lower,
  input  logic [N-1:0]          Cfg_Upper,
  output logic                  Cfg_Error
);

  localparam logic [N-1:0] MID = {1'b1, {(N-1){1'b0}}};

  logic [CHAN_W-1:0] ptr;
  logic [CHAN_W-1:0] gntIdx;
  logic              gntValid;
  logic              outFree;
  logic              accept;
  logic [N-1:0]      gntData;
  logic [N-1:0]      clampY;
  logic [N-1:0]      lowerQ [CHANNELS];
  logic [N-1:0]      upperQ [CHANNELS];
  logic signed [N-1:0] cfgLowerS;
  logic signed [N-1:0] cfgUpperS;
  logic              cfgOk;
  logic              cfgAccept;

  assign outFree = !Out_Valid || Out_Ready;

  // Scan from the highest offset down so the closest valid channel at/after ptr wins.
  always_comb begin
    int idx;
    gntValid = 1'b0;
    gntIdx   = '0;
    idx      = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (In_Valid[idx]) begin
        gntValid = 1'b1;
        gntIdx   = CHAN_W'(idx);
      end
    end
  end

  assign accept = gntValid && outFree && nReset;

  always_comb begin
    In_Ready = '0;
    if (accept) In_Ready[gntIdx] = 1'b1;
  end

  assign gntData = In_Data[int'(gntIdx)*N +: N];

`ifdef LIMIT_SCHEDULER_STATUS_EN
  logic clampClipped;
  logic clippedQ;
  limit_clamp #(.N(N)) uClamp (
    .x       (gntData),
    .lower   (lowerQ[gntIdx]),
    .upper   (upperQ[gntIdx]),
    .y       (clampY),
    .clipped (clampClipped)
  );
`else
  limit_clamp #(.N(N)) uClamp (
    .x       (gntData),
    .lower   (lowerQ[gntIdx]),
    .upper   (upperQ[gntIdx]),
    .y       (clampY),
    .clipped ()
  );
`endif

  assign cfgLowerS = N'(to_signed(MAX_W'(Cfg_Lower), N));
  assign cfgUpperS = N'(to_signed(MAX_W'(Cfg_Upper), N));
  assign cfgOk     = (int'(Cfg_Chan) < CHANNELS) && !(cfgLowerS > cfgUpperS);
  assign cfgAccept = Cfg_Write && cfgOk;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      ptr       <= '0;
      Out_Valid <= 1'b0;
      Out_Data  <= MID;
      Out_Chan  <= '0;
    end else begin
      if (accept) begin
        ptr       <= CHAN_W'((int'(gntIdx) + 1) % CHANNELS);
        Out_Valid <= 1'b1;
        Out_Data  <= clampY;
        Out_Chan  <= gntIdx;
      end else if (Out_Ready) begin
        Out_Valid <= 1'b0;
      end
    end
  end

  // Bounds update after the edge, so a same-cycle accept still sees the old pair.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      Cfg_Error <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        lowerQ[i] <= DEF_LOWER;
        upperQ[i] <= DEF_UPPER;
      end
    end else begin
      Cfg_Error <= Cfg_Write && !cfgOk;
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfgAccept && Cfg_Chan == CHAN_W'(i)) begin
          lowerQ[i] <= Cfg_Lower;
          upperQ[i] <= Cfg_Upper;
        end
      end
    end
  end

`ifdef LIMIT_SCHEDULER_STATUS_EN
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      clippedQ  <= 1'b0;
      Sat_Flags <= '0;
    end else begin
      if (accept) clippedQ <= clampClipped;
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfgAccept && Cfg_Chan == CHAN_W'(i)) Sat_Flags[i] <= 1'b0;
        if (accept && clampClipped && gntIdx == CHAN_W'(i)) Sat_Flags[i] <= 1'b1;
      end
    end
  end

  assign Out_Clipped = Out_Valid && clippedQ;
`endif

endmodule

// File: tb/tb_limit_scheduler.sv
// Directed, table-driven bench for limit_scheduler (N=8, CHANNELS=4, default build).
module tb_limit_scheduler;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic [3:0]  In_Valid = '0;
  logic [3:0]  In_Ready;
  logic [31:0] In_Data = '0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b1;
  logic [7:0]  Out_Data;
  logic [1:0]  Out_Chan;
  logic        Cfg_Write = 1'b0;
  logic [1:0]  Cfg_Chan = '0;
  logic [7:0]  Cfg_Lower = '0;
  logic [7:0]  Cfg_Upper = '0;
  logic        Cfg_Error;

  int testsRun = 0;
  int testsFailed = 0;

  limit_scheduler #(.N(8), .CHANNELS(4)) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Out_Chan  (Out_Chan),
    .Cfg_Write (Cfg_Write),
    .Cfg_Chan  (Cfg_Chan),
    .Cfg_Lower (Cfg_Lower),
    .Cfg_Upper (Cfg_Upper),
    .Cfg_Error (Cfg_Error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         chan;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulseReset();
    nReset = 1'b0;
    #3;
    nReset = 1'b1;
  endtask

  task automatic cfg(input int ch, input logic [7:0] lo, input logic [7:0] hi,
                     input logic expErr, input string nm);
    Cfg_Write = 1'b1;
    Cfg_Chan  = 2'(ch);
    Cfg_Lower = lo;
    Cfg_Upper = hi;
    step();
    Cfg_Write = 1'b0;
    check({nm, "_err"}, int'(Cfg_Error), int'(expErr));
    step();
    check({nm, "_errclr"}, int'(Cfg_Error), 0);
  endtask

  // Single-channel transfer: grant is immediate, result visible one edge later.
  task automatic send(input int ch, input logic [7:0] din, input logic [7:0] exp, input string nm);
    In_Valid = 4'(1 << ch);
    In_Data  = '0;
    In_Data[ch*8 +: 8] = din;
    #1;
    check({nm, "_rdy"}, int'(In_Ready), 1 << ch);
    step();
    In_Valid = '0;
    check({nm, "_vld"}, int'(Out_Valid), 1);
    check({nm, "_data"}, int'(Out_Data), int'(exp));
    check({nm, "_chan"}, int'(Out_Chan), ch);
  endtask

  initial begin
    vec_t vecs[11];
    int   seq[6];

    vecs[0]  = '{1, 8'h60, 8'h70};
    vecs[1]  = '{1, 8'h80, 8'h80};
    vecs[2]  = '{1, 8'hA0, 8'h90};
    vecs[3]  = '{1, 8'h70, 8'h70};
    vecs[4]  = '{1, 8'h90, 8'h90};
    vecs[5]  = '{0, 8'h00, 8'h7F};
    vecs[6]  = '{0, 8'hFF, 8'h80};
    vecs[7]  = '{0, 8'h7F, 8'h7F};
    vecs[8]  = '{0, 8'h80, 8'h80};
    vecs[9]  = '{2, 8'h00, 8'h00};
    vecs[10] = '{3, 8'hFF, 8'hFF};

    #12;
    nReset = 1'b1;
    step();
    check("init_out_valid", int'(Out_Valid), 0);
    check("init_out_data", int'(Out_Data), 8'h80);

    // Reset in the middle of streaming traffic.
    In_Data  = {8'h40, 8'h30, 8'h20, 8'h10};
    In_Valid = 4'hF;
    step();
    step();
    check("pre_rst_chan", int'(Out_Chan), 1);
    nReset = 1'b0;
    #1;
    check("rst_out_valid", int'(Out_Valid), 0);
    check("rst_out_data", int'(Out_Data), 8'h80);
    check("rst_out_chan", int'(Out_Chan), 0);
    check("rst_in_ready", int'(In_Ready), 0);
    check("rst_cfg_error", int'(Cfg_Error), 0);
    @(negedge Clk);
    nReset = 1'b1;
    #1;
    check("post_rst_grant", int'(In_Ready), 4'b0001);
    step();
    check("post_rst_chan", int'(Out_Chan), 0);
    check("post_rst_data", int'(Out_Data), 8'h10);
    In_Valid = '0;
    step();
    step();
    check("idle_valid", int'(Out_Valid), 0);

    // Default bounds pass extremes, then program the windows.
    send(3, 8'h00, 8'h00, "def_lo");
    send(3, 8'hFF, 8'hFF, "def_hi");
    cfg(1, 8'h70, 8'h90, 1'b0, "cfg_ch1");
    cfg(0, 8'h7F, 8'h80, 1'b0, "cfg_ch0");

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].chan, vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));
    end

    // Round robin with every channel requesting, then with ch2 dropped.
    pulseReset();
    In_Data  = {8'h40, 8'h30, 8'h20, 8'h10};
    In_Valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rr_chan%0d", i), int'(Out_Chan), i % 4);
      check($sformatf("rr_data%0d", i), int'(Out_Data), 8'h10 * (i % 4 + 1));
    end
    In_Valid = 4'b1011;
    seq = '{3, 0, 1, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rr_drop%0d", i), int'(Out_Chan), seq[i]);
    end

    // Backpressure: output holds, nothing accepted, nothing lost on release.
    pulseReset();
    In_Valid = 4'hF;
    step();
    Out_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_vld%0d", i), int'(Out_Valid), 1);
      check($sformatf("bp_chan%0d", i), int'(Out_Chan), 0);
      check($sformatf("bp_data%0d", i), int'(Out_Data), 8'h10);
      check($sformatf("bp_rdy%0d", i), int'(In_Ready), 0);
    end
    Out_Ready = 1'b1;
    step();
    check("bp_rel_chan", int'(Out_Chan), 1);
    check("bp_rel_data", int'(Out_Data), 8'h20);
    step();
    check("bp_next_chan", int'(Out_Chan), 2);
    In_Valid = '0;
    step();
    check("bp_drain", int'(Out_Valid), 0);

    // Rejected write, then a write landing in the same cycle as an accept.
    cfg(0, 8'h70, 8'h90, 1'b0, "cfg_ok");
    cfg(0, 8'h90, 8'h80, 1'b1, "cfg_bad");
    send(0, 8'h00, 8'h70, "bad_kept");
    send(0, 8'hFF, 8'h90, "bad_kept_hi");
    Cfg_Write = 1'b1;
    Cfg_Chan  = 2'd0;
    Cfg_Lower = 8'h80;
    Cfg_Upper = 8'h80;
    send(0, 8'h00, 8'h70, "same_cycle_old");
    Cfg_Write = 1'b0;
    check("same_cycle_err", int'(Cfg_Error), 0);
    send(0, 8'h00, 8'h80, "new_bounds_lo");
    send(0, 8'hFF, 8'h80, "new_bounds_hi");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
